byte_serial_wide_adder: RTL and testbench
=========================================

# byte_serial_wide_adder

Sequencer that performs an NBYTES×8-bit addition by streaming byte slices through the 8-bit pipelined carry-select adder (`eight_bit_select_adder`). It sits directly upstream of that adder: it drives the adder's `A`, `B` and `Cin` and consumes `output_sum` and `output_Cout`. It chains each byte's carry-out into the next slice's carry-in and reassembles the wide result. Wide operands enter and results leave through valid/ready handshakes.

## Interface
- `NBYTES`, 4: number of byte slices; operand width is 8·NBYTES.
- `ADDER_LATENCY`, 2: number of rising edges from the adder sampling its operands to its result being stable on `adder_sum`/`adder_cout`; must be ≥1.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset. Top level drives the adder's `reset_n` from `~reset`.
- `in_valid`  in  1  wide operands present.
- `in_ready`  out  1  block can accept operands.
- `in_a`, `in_b`  in  8·NBYTES  addends.
- `in_cin`  in  1  carry-in to byte 0.
- `adder_a`, `adder_b`  out  8  slice operands to the adder.
- `adder_cin`  out  1  slice carry-in to the adder.
- `adder_sum`  in  8  adder sum.
- `adder_cout`  in  1  adder carry-out.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_sum`  out  8·NBYTES  wide sum.
- `out_cout`  out  1  carry-out of the top byte.
- `out_ovf`  out  1  two's-complement signed overflow.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid && in_ready`, register `in_a`, `in_b` and `in_cin`, clear the byte index to 0, and go to ISSUE.
- **ISSUE** (one cycle)
  - Drive `adder_a`/`adder_b` with byte `idx` of the registered operands.
  - Drive `adder_cin` with the registered `in_cin` when `idx`=0, otherwise with the captured carry from the previous slice.
  - Go to WAIT and load the wait counter with ADDER_LATENCY.
- **WAIT**
  - Hold `adder_a`/`adder_b`/`adder_cin` unchanged.
  - Decrement the counter each cycle.
  - In the cycle where the counter reads 1, capture `adder_sum` into result byte `idx` and `adder_cout` into the carry register at the closing edge.
  - If `idx`=NBYTES−1, go to DONE; otherwise increment `idx` and go to ISSUE.
- **DONE**
  - `out_valid`=1.
  - `out_sum`, `out_cout` and `out_ovf` are stable, and `in_ready`=0.
  - On `out_ready`, go to IDLE.
  - No same-cycle accept of new operands: `in_ready` rises in the cycle after the output handshake.
- Outside ISSUE/WAIT, `adder_a`, `adder_b` and `adder_cin` are driven to 0.
- Arithmetic rules:
  - {`out_cout`,`out_sum`} = `in_a` + `in_b` + `in_cin`, full (8·NBYTES+1)-bit result.
  - `out_ovf` = (a_msb == b_msb) && (sum_msb != a_msb).
- `in_valid` is ignored outside IDLE; operand inputs may change freely after acceptance.
- `out_sum`/`out_cout`/`out_ovf` are registered and may show partial values while not `out_valid`. They are meaningful only when `out_valid`=1.

## Timing
- Reset (asynchronous, immediate):
  - State → IDLE.
  - `in_ready`=1 (registered).
  - `out_valid`=0; `out_sum`, `out_cout`, `out_ovf`=0.
  - `adder_a`, `adder_b`, `adder_cin`=0.
  - Internal carry, index and counter=0.
- Let acceptance occur at edge E0.
  - Byte i ISSUE cycle begins after edge E0 + i·(L+1), with L = ADDER_LATENCY.
  - The capture edge for byte i is E0 + i·(L+1) + L + 1.
  - `out_valid` rises after edge E0 + NBYTES·(L+1). For defaults, that is 12 edges after E0.
- Throughput: one wide add per NBYTES·(L+1)+2 cycles when `out_ready` is held high.
- Reset asserted mid-operation aborts the add. Partial results are discarded, no `out_valid` is produced, and `in_ready`=1 after release.
- Backpressure: DONE holds all outputs indefinitely while `out_ready`=0.

## Test plan
The bench instantiates the real `eight_bit_select_adder` behind this block.

1. **Reset:** assert `reset` mid-cycle with no clock edge → all outputs listed under Timing read 0 immediately, `in_ready`=1.
2. **Full carry ripple:** `in_a`=0xFFFFFFFF, `in_b`=0x00000001, `in_cin`=0 → `out_sum`=0x00000000, `out_cout`=1, `out_ovf`=0. `out_valid` rises exactly 12 edges after the accept edge.
3. **Signed overflow via carry-in:** 0x7FFFFFFF + 0x00000000 + `in_cin`=1 → `out_sum`=0x80000000, `out_cout`=0, `out_ovf`=1.
4. **Inter-byte carries:** 0x00FF00FF + 0x00010001 + 0 → `out_sum`=0x01000100, `out_cout`=0. Check `adder_cin`=1 during the byte-1 and byte-3 ISSUE cycles.
5. **Backpressure:** hold `out_ready`=0 for 5 cycles after `out_valid` while toggling `in_valid` and operands → outputs remain stable and `in_ready`=0. After the handshake, `in_ready`=1 on the next cycle.
6. **Reset mid-operation:** pulse `reset` during byte 2 WAIT → `out_valid` never asserts for that add. A following 0x12345678 + 0x11111111 + 0 yields 0x23456789.

Source files
------------

// File: rtl/byte_serial_wide_adder.sv
`default_nettype none
// ============================================================================
//  Module      : byte_serial_wide_adder
//  Description : Sequences an (8*NBYTES)-bit addition through an external
//                8-bit pipelined adder, one byte slice at a time. Each slice's
//                carry-out becomes the next slice's carry-in. The wide result
//                is reassembled and presented on a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk           in   rising-edge clock
//    reset         in   asynchronous active-high reset
//    in_valid_i    in   wide operands present
//    in_ready_o    out  block can accept operands (registered)
//    in_a_i/in_b_i in   8*NBYTES-bit addends
//    in_cin_i      in   carry into byte 0
//    adder_a_o/b_o out  byte slice operands to the 8-bit adder (registered)
//    adder_cin_o   out  slice carry-in to the 8-bit adder (registered)
//    adder_sum_i   in   8-bit adder sum
//    adder_cout_i  in   8-bit adder carry-out
//    out_valid_o   out  result valid
//    out_ready_i   in   downstream accepts the result
//    out_sum_o     out  8*NBYTES-bit sum
//    out_cout_o    out  carry-out of the top byte
//    out_ovf_o     out  two's-complement signed overflow
// ============================================================================
module byte_serial_wide_adder #(
    parameter int NBYTES        = 4,
    parameter int ADDER_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [8*NBYTES-1:0]   in_a_i,
    input  logic [8*NBYTES-1:0]   in_b_i,
    input  logic                  in_cin_i,
    output logic [7:0]            adder_a_o,
    output logic [7:0]            adder_b_o,
    output logic                  adder_cin_o,
    input  logic [7:0]            adder_sum_i,
    input  logic                  adder_cout_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [8*NBYTES-1:0]   out_sum_o,
    output logic                  out_cout_o,
    output logic                  out_ovf_o
);

    localparam int W     = 8 * NBYTES;
    localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int CNT_W = $clog2(ADDER_LATENCY + 1);

    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NBYTES - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(ADDER_LATENCY);
    localparam logic [CNT_W-1:0] CNT_FINAL = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q;
    logic [W-1:0]      a_q;
    logic [W-1:0]      b_q;
    logic [IDX_W-1:0]  idx_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              carry_q;
    logic [W-1:0]      sum_q;
    logic              ovf_q;
    logic              out_valid_q;
    logic              in_ready_q;
    logic [7:0]        adder_a_q;
    logic [7:0]        adder_b_q;
    logic              adder_cin_q;

    // Byte offsets of the current and the following slice.
    logic [IDX_W-1:0]  idx_d;
    logic [IDX_W+2:0]  cur_off;
    logic [IDX_W+2:0]  nxt_off;

    assign idx_d   = idx_q + IDX_W'(1);
    assign cur_off = {idx_q, 3'b000};
    assign nxt_off = {idx_d, 3'b000};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            sum_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            adder_a_q   <= '0;
            adder_b_q   <= '0;
            adder_cin_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // in_ready is always high here, so in_valid alone is the handshake.
                    if (in_valid_i) begin
                        a_q         <= in_a_i;
                        b_q         <= in_b_i;
                        idx_q       <= '0;
                        // Slice 0 operands are loaded straight from the inputs so
                        // they are already on the adder pins during ISSUE.
                        adder_a_q   <= in_a_i[7:0];
                        adder_b_q   <= in_b_i[7:0];
                        adder_cin_q <= in_cin_i;
                        in_ready_q  <= 1'b0;
                        state_q     <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    cnt_q   <= CNT_LOAD;
                    state_q <= S_WAIT;
                end

                S_WAIT: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_FINAL) begin
                        sum_q[cur_off +: 8] <= adder_sum_i;
                        carry_q             <= adder_cout_i;
                        if (idx_q == IDX_LAST) begin
                            // Overflow: like-signed operands, differently-signed result.
                            ovf_q       <= (a_q[W-1] == b_q[W-1]) &&
                                           (adder_sum_i[7] != a_q[W-1]);
                            out_valid_q <= 1'b1;
                            adder_a_q   <= '0;
                            adder_b_q   <= '0;
                            adder_cin_q <= 1'b0;
                            state_q     <= S_DONE;
                        end else begin
                            // The carry being captured this edge feeds the next slice.
                            idx_q       <= idx_d;
                            adder_a_q   <= a_q[nxt_off +: 8];
                            adder_b_q   <= b_q[nxt_off +: 8];
                            adder_cin_q <= adder_cout_i;
                            state_q     <= S_ISSUE;
                        end
                    end
                end

                S_DONE: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign adder_a_o   = adder_a_q;
    assign adder_b_o   = adder_b_q;
    assign adder_cin_o = adder_cin_q;
    assign out_valid_o = out_valid_q;
    assign out_sum_o   = sum_q;
    // The carry register after the last slice is the top-byte carry-out.
    assign out_cout_o  = carry_q;
    assign out_ovf_o   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_byte_serial_wide_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_byte_serial_wide_adder
//  Description : Directed, table-driven bench for byte_serial_wide_adder with
//                an ADDER_LATENCY-deep pipelined 8-bit adder model behind it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_byte_serial_wide_adder;

    localparam int NBYTES        = 4;
    localparam int ADDER_LATENCY = 2;
    localparam int W             = 8 * NBYTES;
    localparam int EXP_LAT       = NBYTES * (ADDER_LATENCY + 1);

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          in_cin;
    logic [7:0]    adder_a;
    logic [7:0]    adder_b;
    logic          adder_cin;
    logic [7:0]    adder_sum;
    logic          adder_cout;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_sum;
    logic          out_cout;
    logic          out_ovf;

    int checks = 0;
    int errors = 0;

    byte_serial_wide_adder #(
        .NBYTES        (NBYTES),
        .ADDER_LATENCY (ADDER_LATENCY)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_a_i       (in_a),
        .in_b_i       (in_b),
        .in_cin_i     (in_cin),
        .adder_a_o    (adder_a),
        .adder_b_o    (adder_b),
        .adder_cin_o  (adder_cin),
        .adder_sum_i  (adder_sum),
        .adder_cout_i (adder_cout),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_sum_o    (out_sum),
        .out_cout_o   (out_cout),
        .out_ovf_o    (out_ovf)
    );

    // Pipelined 8-bit adder: operands sampled at the first edge, result
    // stable after ADDER_LATENCY edges counted from that sampling edge.
    logic [8:0] pipe [ADDER_LATENCY];
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ADDER_LATENCY; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= {1'b0, adder_a} + {1'b0, adder_b} + {8'b0, adder_cin};
            for (int i = 1; i < ADDER_LATENCY; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign adder_sum  = pipe[ADDER_LATENCY-1][7:0];
    assign adder_cout = pipe[ADDER_LATENCY-1][8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Offers operands in IDLE; returns just after the accept edge.
    task automatic start_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        @(negedge clk);
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_valid = 1'b1;
        chk("in_ready_before_accept", {63'b0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a     = W'($urandom);
        in_b     = W'($urandom);
        in_cin   = 1'($urandom);
    endtask

    // Counts edges after the accept edge until out_valid is seen.
    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!out_valid) begin
            errors++;
            $display("FAIL out_valid_timeout: got 0 expected 1");
        end
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] s, input logic c, input logic o);
        chk({tag, "_sum"},  64'(out_sum),  64'(s));
        chk({tag, "_cout"}, {63'b0, out_cout}, {63'b0, c});
        chk({tag, "_ovf"},  {63'b0, out_ovf},  {63'b0, o});
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("out_valid_after_hs", {63'b0, out_valid}, 64'd0);
        chk("in_ready_after_hs",  {63'b0, in_ready},  64'd1);
    endtask

    initial begin
        int           n;
        logic         saw;
        logic [W-1:0] hold_sum;

        vecs[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vecs[1] = '{32'h7FFFFFFF, 32'h00000000, 1'b1, 32'h80000000, 1'b0, 1'b1};
        vecs[2] = '{32'h00FF00FF, 32'h00010001, 1'b0, 32'h01000100, 1'b0, 1'b0};
        vecs[3] = '{32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0};
        vecs[4] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
        vecs[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
        vecs[6] = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0};
        vecs[7] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        out_ready = 1'b0;
        #12;
        chk("por_in_ready",  {63'b0, in_ready},  64'd1);
        chk("por_out_valid", {63'b0, out_valid}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Table of full adds, each with latency check and handshake.
        for (int i = 0; i < 8; i++) begin
            start_add(vecs[i].a, vecs[i].b, vecs[i].cin);
            wait_valid(n);
            chk($sformatf("vec%0d_latency", i), 64'(n), 64'(EXP_LAT));
            check_result($sformatf("vec%0d", i), vecs[i].sum, vecs[i].cout, vecs[i].ovf);
            handshake();
        end

        // Inter-byte carries seen on the adder during each slice's ISSUE cycle.
        start_add(32'h00FF00FF, 32'h00010001, 1'b0);
        chk("issue0_cin", {63'b0, adder_cin}, 64'd0);
        chk("issue0_a",   64'(adder_a), 64'hFF);
        repeat (ADDER_LATENCY + 1) @(posedge clk);
        #1;
        chk("issue1_cin", {63'b0, adder_cin}, 64'd1);
        chk("issue1_a",   64'(adder_a), 64'h00);
        repeat (ADDER_LATENCY + 1) @(posedge clk);
        #1;
        chk("issue2_cin", {63'b0, adder_cin}, 64'd0);
        chk("issue2_a",   64'(adder_a), 64'hFF);
        repeat (ADDER_LATENCY + 1) @(posedge clk);
        #1;
        chk("issue3_cin", {63'b0, adder_cin}, 64'd1);
        chk("issue3_b",   64'(adder_b), 64'h00);
        wait_valid(n);
        check_result("carry_seq", 32'h01000100, 1'b0, 1'b0);
        chk("done_adder_a", 64'(adder_a), 64'h0);
        handshake();

        // Backpressure: DONE holds while operands and in_valid churn.
        start_add(32'h80000000, 32'h80000000, 1'b0);
        wait_valid(n);
        hold_sum = out_sum;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_valid = ~in_valid;
            in_a     = W'($urandom);
            in_b     = W'($urandom);
            in_cin   = 1'($urandom);
            @(posedge clk);
            #1;
            chk("bp_out_valid", {63'b0, out_valid}, 64'd1);
            chk("bp_in_ready",  {63'b0, in_ready},  64'd0);
            chk("bp_sum",       64'(out_sum), 64'(hold_sum));
        end
        check_result("bp", 32'h00000000, 1'b1, 1'b1);
        in_valid = 1'b0;
        handshake();

        // Asynchronous reset between edges while results are held.
        start_add(32'h12345678, 32'h11111111, 1'b0);
        wait_valid(n);
        check_result("pre_rst", 32'h23456789, 1'b0, 1'b0);
        #3;
        reset = 1'b1;
        #1;
        chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("rst_out_sum",   64'(out_sum), 64'h0);
        chk("rst_out_cout",  {63'b0, out_cout}, 64'd0);
        chk("rst_out_ovf",   {63'b0, out_ovf},  64'd0);
        chk("rst_in_ready",  {63'b0, in_ready}, 64'd1);
        chk("rst_adder_ab",  {48'b0, adder_a, adder_b}, 64'h0);
        chk("rst_adder_cin", {63'b0, adder_cin}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Reset during byte 2 WAIT aborts the add.
        start_add(32'hAAAAAAAA, 32'h55555555, 1'b0);
        repeat (2 * (ADDER_LATENCY + 1) + 1) @(posedge clk);
        #1;
        chk("byte2_wait_a", 64'(adder_a), 64'hAA);
        #2;
        reset = 1'b1;
        #1;
        chk("midop_rst_adder_a", 64'(adder_a), 64'h0);
        @(negedge clk);
        reset = 1'b0;
        saw = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) saw = 1'b1;
        end
        chk("midop_no_valid", {63'b0, saw}, 64'd0);
        chk("midop_in_ready", {63'b0, in_ready}, 64'd1);
        start_add(32'h12345678, 32'h11111111, 1'b0);
        wait_valid(n);
        chk("post_rst_latency", 64'(n), 64'(EXP_LAT));
        check_result("post_rst", 32'h23456789, 1'b0, 1'b0);
        handshake();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
